// File: rtl/jacobi_pkg.sv
// jacobi_pkg: shared FSM state type, pair-count helper and default index type for the Jacobi sequencer
package jacobi_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_e;
  localparam int N_STOCKS_DEF = 4;
  typedef logic [$clog2(N_STOCKS_DEF)-1:0] idx_t;
  function automatic int n_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction
endpackage

// File: rtl/jacobi_pair_gen.sv
// jacobi_pair_gen: row-major off-diagonal pivot pair counter (p,q) with q always above p
module jacobi_pair_gen #(
  parameter int N_STOCKS = 4,
  parameter int IW = $clog2(N_STOCKS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          clear_in,
  input  logic          advance_in,
  output logic [IW-1:0] p_out,
  output logic [IW-1:0] q_out,
  output logic          last_out
);
  logic [IW-1:0] p_q, q_q, p_d, q_d;
  logic wrap;
  assign wrap = q_q == IW'(N_STOCKS - 1);
  assign last_out = wrap && p_q == IW'(N_STOCKS - 2);
  assign p_out = p_q;
  assign q_out = q_q;
  // next pair: wrap to (0,1) after the last pair, otherwise step q or move to the next row
  always_comb begin
    p_d = (clear_in || (advance_in && last_out)) ? '0 : (advance_in && wrap) ? p_q + IW'(1) : p_q;
    q_d = (clear_in || (advance_in && last_out)) ? IW'(1) :
          advance_in ? (wrap ? p_q + IW'(2) : q_q + IW'(1)) : q_q;
  end
  // pair registers, reset to the first pair (0,1)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_q <= '0;
      q_q <= IW'(1);
    end else begin
      p_q <= p_d;
      q_q <= q_d;
    end
  end
endmodule

// File: rtl/jacobi_sched.sv
// jacobi_sched: sweep sequencer issuing Jacobi pivot pairs and tracking convergence, sweep limit and abort
module jacobi_sched
  import jacobi_pkg::*;
#(
  parameter int N_STOCKS = 4,
  parameter int MAX_SWEEPS = 8,
  parameter int SW = $clog2(MAX_SWEEPS + 1),
  parameter int IW = $clog2(N_STOCKS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic          abort_in,
  input  logic          conv_in,
  output logic          rot_valid_out,
  input  logic          rot_ready_in,
  output logic [IW-1:0] rot_p_out,
  output logic [IW-1:0] rot_q_out,
  input  logic          rot_done_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          converged_out,
  output logic [SW-1:0] sweeps_out
);
  state_e state_q, state_d;
  logic [SW-1:0] sweeps_q, sweeps_d;
  logic conv_q, conv_d, abort_q, abort_d;
  logic valid_q, busy_q, done_q;
  logic clear, advance, last, any_abort;

  jacobi_pair_gen #(.N_STOCKS(N_STOCKS), .IW(IW)) u_pair (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (clear),
    .advance_in(advance),
    .p_out     (rot_p_out),
    .q_out     (rot_q_out),
    .last_out  (last)
  );

  assign any_abort = abort_q || abort_in;
  assign rot_valid_out = valid_q;
  assign busy_out = busy_q;
  assign done_out = done_q;
  assign converged_out = conv_q;
  assign sweeps_out = sweeps_q;

  // next-state logic; an abort during WAIT is parked until the in-flight rotation completes
  always_comb begin
    state_d = state_q;
    sweeps_d = sweeps_q;
    conv_d = conv_q;
    abort_d = abort_q;
    clear = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = CHECK;
        sweeps_d = '0;
        conv_d = 1'b0;
        abort_d = 1'b0;
        clear = 1'b1;
      end
      CHECK: begin
        state_d = (abort_in || conv_in || sweeps_q == SW'(MAX_SWEEPS)) ? DONE : ISSUE;
        conv_d = !abort_in && conv_in;
      end
      ISSUE: begin
        state_d = abort_in ? DONE : rot_ready_in ? WAIT : ISSUE;
        conv_d = abort_in ? 1'b0 : conv_q;
      end
      WAIT: begin
        abort_d = any_abort;
        if (rot_done_in) begin
          state_d = any_abort ? DONE : last ? CHECK : ISSUE;
          advance = !any_abort;
          sweeps_d = (!any_abort && last) ? sweeps_q + SW'(1) : sweeps_q;
          conv_d = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs, all decoded from the next state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sweeps_q <= '0;
      conv_q <= 1'b0;
      abort_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweeps_q <= sweeps_d;
      conv_q <= conv_d;
      abort_q <= abort_d;
      valid_q <= state_d == ISSUE;
      busy_q <= state_d != IDLE;
      done_q <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_jacobi_sched.sv
// tb_jacobi_sched: randomized transaction-level check of the Jacobi pivot sequencer
module tb_jacobi_sched;
  localparam int N = 4;
  localparam int MS = 3;
  localparam int SW = $clog2(MS + 1);
  localparam int IW = $clog2(N);
  localparam int NP = jacobi_pkg::n_pairs(N);

  logic clk_in = 1'b0;
  logic rst_in, start_in, abort_in, conv_in, rot_ready_in, rot_done_in;
  logic rot_valid_out, busy_out, done_out, converged_out;
  logic [IW-1:0] rot_p_out, rot_q_out;
  logic [SW-1:0] sweeps_out;
  int errors = 0;
  int checks = 0;
  int pp[$];
  int qq[$];

  always #5 clk_in = ~clk_in;

  jacobi_sched #(.N_STOCKS(N), .MAX_SWEEPS(MS)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .abort_in     (abort_in),
    .conv_in      (conv_in),
    .rot_valid_out(rot_valid_out),
    .rot_ready_in (rot_ready_in),
    .rot_p_out    (rot_p_out),
    .rot_q_out    (rot_q_out),
    .rot_done_in  (rot_done_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .converged_out(converged_out),
    .sweeps_out   (sweeps_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // one decomposition: conv_in rises once conv_after sweeps have completed;
  // rmode 0 ready always, 1 random ready, 2 ready held low 5 cycles per pair;
  // amode 0 none, 1 abort at a random cycle, 2 abort in WAIT on (1,2), 3 abort in ISSUE
  task automatic episode(input int conv_after, input int rmode, input int amode);
    int cyc, hs, completed, cnt, blk, abort_at, exp_done, es, ab_rot;
    bit inflight, aborted, ab_now, rdy, pulse, real_pulse, pv, pr, pa, ec;
    logic [IW-1:0] lp, lq;
    abort_at = $urandom_range(1, 60);
    hs = 0; completed = 0; cnt = 0; blk = 0; ab_rot = 0;
    inflight = 0; aborted = 0; pv = 0; pr = 0; pa = 0; lp = '0; lq = '0;
    exp_done = (conv_after == 0) ? 1 : -1;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    chk("busy_after_start", busy_out, 1);
    for (cyc = 0; cyc < 3000 && !done_out; cyc++) begin
      if (pv && !pr && !pa) begin
        chk("valid_hold", rot_valid_out, 1);
        chk("p_hold", rot_p_out, lp);
        chk("q_hold", rot_q_out, lq);
      end
      if (aborted) chk("no_valid_after_abort", rot_valid_out, 0);
      conv_in = completed >= NP * conv_after;
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 2) != 0) : (blk >= 5);
      if (rot_valid_out && !rdy) blk++;
      real_pulse = inflight && cnt == 0;
      if (inflight && cnt > 0) cnt--;
      pulse = real_pulse || (!inflight && $urandom_range(0, 4) == 0);
      ab_now = !aborted && busy_out && !done_out &&
               ((amode == 1 && cyc == abort_at) || (amode == 2 && inflight && hs == 4) ||
                (amode == 3 && rot_valid_out && hs == 2));
      start_in = busy_out && $urandom_range(0, 6) == 0;
      rot_ready_in = rdy;
      rot_done_in = pulse;
      abort_in = ab_now;
      if (ab_now) begin
        aborted = 1;
        if (!inflight) exp_done = cyc + 1;
      end
      if (real_pulse) begin
        inflight = 0;
        if (aborted) begin
          exp_done = cyc + 1;
          ab_rot = 1;
        end else completed++;
      end
      if (rot_valid_out && rdy && !ab_now) begin
        chk("pair_p", rot_p_out, pp[hs % NP]);
        chk("pair_q", rot_q_out, qq[hs % NP]);
        hs++;
        inflight = 1;
        cnt = $urandom_range(0, 3);
        blk = 0;
      end
      pv = rot_valid_out; pr = rdy; pa = ab_now; lp = rot_p_out; lq = rot_q_out;
      tick;
    end
    chk("done_seen", done_out, 1);
    if (exp_done >= 0) chk("done_latency", cyc, exp_done);
    if (aborted) begin ec = 0; es = completed / NP; end
    else if (conv_after <= MS) begin ec = 1; es = conv_after; end
    else begin ec = 0; es = MS; end
    chk("converged", converged_out, ec);
    chk("sweeps", sweeps_out, es);
    chk("busy_in_done", busy_out, 1);
    chk("handshakes", hs, aborted ? completed + ab_rot : es * NP);
    start_in = 1'b0; abort_in = 1'b0; rot_done_in = 1'b0; rot_ready_in = 1'b0;
    tick;
    chk("busy_after_done", busy_out, 0);
    chk("done_one_cycle", done_out, 0);
    chk("converged_held", converged_out, ec);
    chk("sweeps_held", sweeps_out, es);
  endtask

  initial begin
    for (int p = 0; p < N; p++)
      for (int q = p + 1; q < N; q++) begin
        pp.push_back(p);
        qq.push_back(q);
      end
    rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; conv_in = 1'b0;
    rot_ready_in = 1'b0; rot_done_in = 1'b0;
    tick; tick;
    rst_in = 1'b0;
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_valid", rot_valid_out, 0);
    chk("rst_conv", converged_out, 0);
    chk("rst_sweeps", sweeps_out, 0);
    chk("rst_p", rot_p_out, 0);
    chk("rst_q", rot_q_out, 1);
    episode(0, 0, 0);
    episode(2, 0, 0);
    episode(MS + 2, 0, 0);
    episode(3, 2, 0);
    episode(4, 1, 2);
    episode(4, 1, 3);
    for (int i = 0; i < 20; i++) episode($urandom_range(0, MS + 1), $urandom_range(0, 2), $urandom_range(0, 1));
    start_in = 1'b1; conv_in = 1'b0; rot_ready_in = 1'b1;
    tick;
    start_in = 1'b0;
    tick;
    chk("pre_rst_valid", rot_valid_out, 1);
    tick;
    chk("pre_rst_wait", rot_valid_out, 0);
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_done", done_out, 0);
    chk("midrst_valid", rot_valid_out, 0);
    chk("midrst_p", rot_p_out, 0);
    chk("midrst_q", rot_q_out, 1);
    rot_done_in = 1'b1;
    tick;
    rot_done_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_done", done_out, 0);
      chk("midrst_idle", busy_out, 0);
      tick;
    end
    episode(1, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
